// File: rtl/display_if.sv
// display_if: request/frame/blink inputs and grant/digit/enable outputs of the display arbiter.
interface display_if;
    logic [1:0]  req;
    logic [31:0] frame0;
    logic [31:0] frame1;
    logic        blink0;
    logic        blink1;
    logic [1:0]  ack;
    logic        owner;
    logic [3:0]  digital1, digital2, digital3, digital4;
    logic [3:0]  digital5, digital6, digital7, digital8;
    logic        en;
    modport master (output req, frame0, frame1, blink0, blink1,
                    input ack, owner, en, digital1, digital2, digital3, digital4,
                    digital5, digital6, digital7, digital8);
    modport slave (input req, frame0, frame1, blink0, blink1,
                   output ack, owner, en, digital1, digital2, digital3, digital4,
                   digital5, digital6, digital7, digital8);
endinterface

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin ownership of an 8-digit display between two requesters,
// with a minimum hold time and optional blinking.
module display_arbiter #(
    parameter int TICK_DIV    = 100000,
    parameter int HOLD_TICKS  = 1000,
    parameter int BLINK_TICKS = 250
) (
    input logic      clk,
    input logic      rst_n,
    display_if.slave bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    typedef enum logic [1:0] {IDLE, GRANT, SHOW, RELEASE} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tick_cnt;
    logic [HW-1:0] hold;
    logic [BW-1:0] blink_cnt, blink_nx;
    logic          tick, phase, phase_nx, last_owner, winner;
    logic          owner_req, other_req, own_blink;
    logic [31:0]   frame_q, owner_frame;

    assign tick        = tick_cnt == TW'(TICK_DIV - 1);
    assign owner_req   = bus.req[bus.owner];
    assign other_req   = bus.req[~bus.owner];
    assign own_blink   = bus.owner ? bus.blink1 : bus.blink0;
    assign owner_frame = bus.owner ? bus.frame1 : bus.frame0;
    // On contention the requester that did not own the display last time wins.
    assign winner      = (bus.req == 2'b11) ? ~last_owner : bus.req[1];

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        blink_nx = blink_cnt;
        case (state)
            IDLE:    if (|bus.req) state_nx = GRANT;
            GRANT: begin
                state_nx = SHOW;
                phase_nx = 1'b1;
                blink_nx = '0;
            end
            SHOW: begin
                if (hold == HW'(HOLD_TICKS) && (!owner_req || other_req)) state_nx = RELEASE;
                if (!own_blink) begin
                    phase_nx = 1'b1;
                    blink_nx = '0;
                end else if (tick) begin
                    phase_nx = (blink_cnt == BW'(BLINK_TICKS - 1)) ? ~phase : phase;
                    blink_nx = (blink_cnt == BW'(BLINK_TICKS - 1)) ? '0 : blink_cnt + BW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            hold       <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b1;
            last_owner <= 1'b1;
            frame_q    <= '0;
            bus.ack    <= 2'b00;
            bus.owner  <= 1'b0;
            bus.en     <= 1'b0;
        end else begin
            state     <= state_nx;
            tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
            phase     <= phase_nx;
            blink_cnt <= blink_nx;
            bus.en    <= (state_nx == SHOW) && phase_nx;
            bus.ack   <= (state == IDLE && |bus.req) ? (winner ? 2'b10 : 2'b01) : 2'b00;
            if (state == IDLE && |bus.req) begin
                bus.owner <= winner;
                frame_q   <= winner ? bus.frame1 : bus.frame0;
            end
            if (state == GRANT || (state == SHOW && owner_req)) frame_q <= owner_frame;
            hold <= (state == GRANT) ? '0 :
                    (state == SHOW && tick && hold != HW'(HOLD_TICKS)) ? hold + HW'(1) : hold;
            if (state == RELEASE) last_owner <= bus.owner;
        end
    end

    assign bus.digital1 = frame_q[3:0];
    assign bus.digital2 = frame_q[7:4];
    assign bus.digital3 = frame_q[11:8];
    assign bus.digital4 = frame_q[15:12];
    assign bus.digital5 = frame_q[19:16];
    assign bus.digital6 = frame_q[23:20];
    assign bus.digital7 = frame_q[27:24];
    assign bus.digital8 = frame_q[31:28];
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed checks of grant, hold, blink, frame tracking and reset
// with TICK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2.
module tb_display_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;

    always #5 clk = ~clk;

    display_if bus();
    display_arbiter #(.TICK_DIV(4), .HOLD_TICKS(3), .BLINK_TICKS(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    function automatic logic [31:0] digits();
        return {bus.digital8, bus.digital7, bus.digital6, bus.digital5,
                bus.digital4, bus.digital3, bus.digital2, bus.digital1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_ack(input string tag, input logic [1:0] exp);
        int k = 0;
        while (bus.ack == 2'b00 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(bus.ack), 32'(exp));
    endtask

    // Number of consecutive sampled cycles (starting now) with en equal to val.
    task automatic run_len(input logic val, output int len);
        len = 0;
        while (bus.en === val && len < 100) begin
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = 2'b00; bus.frame0 = '0; bus.frame1 = '0; bus.blink0 = 1'b0; bus.blink1 = 1'b0;
        cyc(2);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_en", 32'(bus.en), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_digits", digits(), 32'd0);
        rst_n = 1'b1;
        cyc(1);
        // single requester 0
        bus.frame0 = 32'h87654321;
        bus.req = 2'b01;
        cyc(1);
        chk("grant0_ack", 32'(bus.ack), 32'h1);
        cyc(1);
        chk("grant0_ack_pulse", 32'(bus.ack), 32'h0);
        chk("show0_en", 32'(bus.en), 32'h1);
        chk("show0_owner", 32'(bus.owner), 32'h0);
        chk("show0_digits", digits(), 32'h87654321);
        // live frame tracking
        bus.frame0 = 32'h00000000;
        cyc(1);
        chk("frame_zero", digits(), 32'h00000000);
        bus.frame0 = 32'hFFFFFFFF;
        cyc(1);
        chk("frame_ones", digits(), 32'hFFFFFFFF);
        // blinking: 8 cycles off, 8 on
        bus.blink0 = 1'b1;
        n = 0;
        while (bus.en && n < 40) begin
            @(negedge clk);
            n++;
        end
        run_len(1'b0, n);
        chk("blink_off_len", 32'(n), 32'd8);
        run_len(1'b1, n);
        chk("blink_on_len", 32'(n), 32'd8);
        bus.blink0 = 1'b0;
        cyc(1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.en) n++;
            @(negedge clk);
        end
        chk("blink_off_steady", 32'(n), 32'd10);
        // hold long expired: dropping the request releases at once
        bus.req = 2'b00;
        cyc(1);
        chk("release_en", 32'(bus.en), 32'h0);
        cyc(1);
        chk("idle_ack", 32'(bus.ack), 32'h0);
        chk("idle_owner_kept", 32'(bus.owner), 32'h0);
        // one-cycle pulse still gets the full hold, frame frozen
        bus.frame0 = 32'h13579BDF;
        bus.req = 2'b01;
        cyc(1);
        chk("pulse_ack", 32'(bus.ack), 32'h1);
        bus.req = 2'b00;
        cyc(1);
        bus.frame0 = 32'h2468ACE0;
        run_len(1'b1, n);
        chk("pulse_hold_len", 32'(n >= 10 && n <= 13), 32'd1);
        chk("pulse_frozen", digits(), 32'h13579BDF);
        cyc(3);
        chk("pulse_idle_en", 32'(bus.en), 32'h0);
        chk("pulse_idle_ack", 32'(bus.ack), 32'h0);
        // contention after reset: 0 first, then 1
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        bus.frame0 = 32'h11223344;
        bus.frame1 = 32'hCAFEF00D;
        bus.req = 2'b11;
        cyc(1);
        chk("both_first_ack", 32'(bus.ack), 32'h1);
        cyc(1);
        run_len(1'b1, n);
        chk("both_hold_len", 32'(n >= 10 && n <= 13), 32'd1);
        wait_ack("both_second_ack", 2'b10);
        chk("both_second_owner", 32'(bus.owner), 32'h1);
        cyc(1);
        chk("both_second_en", 32'(bus.en), 32'h1);
        chk("both_second_digits", digits(), 32'hCAFEF00D);
        // asynchronous reset mid-show
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_ack", 32'(bus.ack), 32'h0);
        chk("areset_en", 32'(bus.en), 32'h0);
        chk("areset_owner", 32'(bus.owner), 32'h0);
        chk("areset_digits", digits(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        chk("areset_regrant", 32'(bus.ack), 32'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter TICK_DIV, default 100000, Clk cycles per internal tick (1 ms at 100 MHz), legal range >=2.
REQ-002 Parameter HOLD_TICKS, default 1000, minimum ownership time in ticks, legal range >=1.
REQ-003 Parameter BLINK_TICKS, default 250, blink half-period in ticks, legal range >=1.
REQ-004 Clk  input  1  system clock, 100 MHz, rising edge.
REQ-005 Rst_n  input  1  asynchronous active-low reset.
REQ-006 Req  input  2  per-requester display request, level, bit i = requester i.
REQ-007 Frame0, Frame1  input  32 each  requester digit frame, nibble k-1 (bits 4k-1..4k-4) = digit k, k=1..8.
REQ-008 Blink0, Blink1  input  1 each  requester blink enable, sampled while that requester owns the display.
REQ-009 Ack  output  2  one-cycle grant pulse, bit i = requester i.
REQ-010 Owner  output  1  index of current or last owner.
REQ-011 Digital1..Digital8  output  4 each  digit values for the existing Display block.
REQ-012 En  output  1  display enable for the existing Display block.

Function
REQ-013 A free-running tick counter SHALL count 0..TICK_DIV-1 and assert an internal tick for one cycle on wrap.
REQ-014 The FSM SHALL have states IDLE, GRANT, SHOW and RELEASE.
REQ-015 IDLE: En=0; if any Req bit is set, the FSM SHALL select the winner and go to GRANT next cycle, else stay.
REQ-016 Arbitration: single requester wins; if both request, the requester that is not last_owner wins (round-robin).
REQ-017 GRANT (one cycle): Ack[winner]=1, Owner<=winner, frame register<=winner's Frame, hold counter<=0, blink phase<=on; next state SHOW.
REQ-018 SHOW: the frame register SHALL reload from the owner's Frame every cycle while Req[Owner]=1, and hold its last value once Req[Owner]=0.
REQ-019 SHOW: the hold counter SHALL increment on each tick and saturate at HOLD_TICKS.
REQ-020 SHOW exits to RELEASE when hold counter==HOLD_TICKS and (Req[Owner]=0 or Req[other]=1); otherwise it stays.
REQ-021 RELEASE (one cycle): En=0, last_owner<=Owner; next state IDLE; Owner is unchanged.
REQ-022 Blink: in SHOW, with the owner's Blink=1, the blink phase SHALL toggle every BLINK_TICKS ticks; with Blink=0, the phase is forced on.
REQ-023 En SHALL be 1 only in SHOW with blink phase on; En is registered.
REQ-024 Digitalk SHALL equal frame register nibble k-1 in every state; all Digital outputs are registered.
REQ-025 Worst-case latency from Req assertion in IDLE to En=1 SHALL be 3 cycles: IDLE sample, GRANT, SHOW with En registered.
REQ-026 A Req pulse shorter than the hold time SHALL still receive the full HOLD_TICKS display.
REQ-027 Ack SHALL never have both bits set, and SHALL never be asserted outside GRANT.

Reset
REQ-028 Rst_n=0 SHALL immediately force state IDLE, Ack=0, Owner=0, En=0, Digital1..8=0, tick, hold and blink counters=0, blink phase=on, and last_owner=1.
REQ-029 Reset asserted mid-SHOW SHALL abort ownership with no Ack; after release, arbitration restarts with requester 0 favoured.

Verification (TICK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2)
REQ-030 Reset release, then Req=01, Frame0=0x87654321 -> Ack=01 for 1 cycle, then En=1, Digital1=1 ... Digital8=8, Owner=0.
REQ-031 Req=11 from IDLE after reset -> requester 0 granted; after 12 cycles in SHOW, RELEASE then IDLE then Ack=10, Owner=1, Frame1 shown.
REQ-032 Req0 held for 1 cycle only -> frame frozen at the granted value; En=1 until the hold counter reaches 3, then RELEASE, En=0, IDLE.
REQ-033 Owner Blink=1 -> En pattern in SHOW is on for 8 cycles, off for 8 cycles, repeating; Blink=0 -> En steady 1.
REQ-034 Frame0 changes from 0x00000000 to 0xFFFFFFFF while Req0=1 in SHOW -> all Digital outputs = F one cycle later.
REQ-035 Rst_n pulsed low in SHOW -> all outputs 0 in the same cycle; with Req=11 held, next grant goes to requester 0.
